// File: rtl/argmax_result_fifo_if.sv
// argmax_result_fifo_if: valid/ready result port carrying one encoded class index
//   valid : head entry available (master -> slave)
//   ready : consumer accepts head entry (slave -> master)
//   index : class index of head entry (master -> slave)
interface argmax_result_fifo_if #(
  parameter int IDX_WIDTH = 4
);
  logic                 valid;
  logic                 ready;
  logic [IDX_WIDTH-1:0] index;
  modport master (output valid, index, input ready);
  modport slave  (input valid, index, output ready);
endinterface

// File: rtl/argmax_result_fifo.sv
// argmax_result_fifo: one-hot argmax encoder feeding a first-word-fall-through result FIFO
//   clk, reset   : clock, synchronous active-high reset
//   maxi         : one-hot argmax in, all-zero means no result this cycle
//   out          : valid/ready/index result port (master side)
//   full, empty  : FIFO holds DEPTH / 0 entries
//   level        : entry count 0..DEPTH
//   result_count : accepted results, wraps silently
//   onehot_err   : sticky, multi-hot maxi seen
//   overflow     : sticky, result dropped on a full FIFO
module argmax_result_fifo #(
  parameter int LENGTH    = 10,
  parameter int IDX_WIDTH = 4,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LENGTH-1:0]        maxi,
  argmax_result_fifo_if.master     out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_WIDTH-1:0]     result_count,
  output logic                     onehot_err,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [IDX_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]          level_q, level_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 oh_q, oh_d, ovf_q, ovf_d;
  logic [IDX_WIDTH-1:0] idx;
  logic                 ev, push, pop;
  // downward scan so the lowest set bit wins on a multi-hot input
  always_comb begin
    idx = '0;
    for (int i = LENGTH - 1; i >= 0; i--) if (maxi[i]) idx = IDX_WIDTH'(i);
  end
  assign ev    = |maxi;
  assign empty = level_q == '0;
  assign full  = level_q == (AW + 1)'(DEPTH);
  assign pop   = !empty && out.ready;
  assign push  = ev && (!full || pop);
  always_comb begin
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    level_d = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
    cnt_d   = cnt_q + CNT_WIDTH'(push);
    oh_d    = oh_q | ((maxi & (maxi - 1'b1)) != '0);
    ovf_d   = ovf_q | (ev && full && !pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      oh_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      oh_q    <= oh_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk) if (!reset && push) mem_q[wr_q] <= idx;
  assign out.valid    = !empty;
  assign out.index    = empty ? '0 : mem_q[rd_q];
  assign level        = level_q;
  assign result_count = cnt_q;
  assign onehot_err   = oh_q;
  assign overflow     = ovf_q;
endmodule

// File: tb/tb_argmax_result_fifo.sv
// tb_argmax_result_fifo: queue-model scoreboard for the argmax result FIFO
module tb_argmax_result_fifo;
  localparam int DEPTH = 8;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] maxi = '0;
  logic       full, empty, onehot_err, overflow;
  logic [3:0] level;
  logic [15:0] result_count;
  argmax_result_fifo_if #(.IDX_WIDTH(4)) ifc ();
  argmax_result_fifo #(.LENGTH(10), .IDX_WIDTH(4), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .maxi(maxi), .out(ifc.master), .full(full), .empty(empty),
    .level(level), .result_count(result_count), .onehot_err(onehot_err), .overflow(overflow)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int m_cnt = 0;
  bit m_oh = 0, m_ovf = 0;
  int e_lvl = 0, e_head = 0, e_cnt = 0;
  bit e_oh = 0, e_ovf = 0;
  bit chk_en = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic step(input logic [9:0] m, input logic r, input logic rs);
    int cur, idx, ones;
    bit pop;
    @(posedge clk);
    #1;
    maxi = m;
    ifc.ready = r;
    reset = rs;
    cur = exp_q.size();
    e_lvl = cur;
    e_head = cur > 0 ? exp_q[0] : 0;
    e_cnt = m_cnt;
    e_oh = m_oh;
    e_ovf = m_ovf;
    if (rs) begin
      exp_q.delete();
      m_cnt = 0;
      m_oh = 0;
      m_ovf = 0;
    end else begin
      pop = cur > 0 && r;
      if (m != 0) begin
        idx = -1;
        ones = 0;
        for (int i = 0; i < 10; i++) if (m[i]) begin
          ones++;
          if (idx < 0) idx = i;
        end
        if (ones > 1) m_oh = 1;
        if (cur < DEPTH || pop) begin
          exp_q.push_back(idx);
          m_cnt = (m_cnt + 1) % 65536;
        end else m_ovf = 1;
      end
    end
    chk_en = 1;
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("level", 32'(level), 32'(e_lvl));
    chk("empty", 32'(empty), 32'(e_lvl == 0));
    chk("full", 32'(full), 32'(e_lvl == DEPTH));
    chk("out_valid", 32'(ifc.valid), 32'(e_lvl != 0));
    chk("result_count", 32'(result_count), 32'(e_cnt));
    chk("onehot_err", 32'(onehot_err), 32'(e_oh));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    if (ifc.valid === 1'b1 && ifc.ready && !reset) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'(1), 32'(0));
      else chk("pop_index", 32'(ifc.index), 32'(exp_q.pop_front()));
    end else chk("out_index", 32'(ifc.index), 32'(e_head));
  end
  initial begin
    logic [9:0] m;
    ifc.ready = 1'b0;
    step(10'b0, 0, 1);
    step(10'b0, 0, 0);
    step(10'b0000001000, 0, 0);
    step(10'b0, 1, 0);
    step(10'b0, 1, 0);
    step(10'b0, 0, 0);
    for (int k = 0; k < 8; k++) step(10'(1 << k), 0, 0);
    step(10'b1000000000, 0, 0);
    step(10'b0, 0, 0);
    for (int k = 0; k < 9; k++) step(10'b0, 1, 0);
    step(10'b0, 0, 1);
    for (int k = 0; k < 8; k++) step(10'(1 << k), 0, 0);
    step(10'b0000100000, 1, 0);
    step(10'b0, 0, 0);
    for (int k = 0; k < 9; k++) step(10'b0, 1, 0);
    step(10'b0000010100, 0, 0);
    step(10'b0, 0, 0);
    step(10'b0001000000, 1, 0);
    step(10'b0000000010, 1, 0);
    for (int k = 0; k < 4; k++) step(10'b0, 1, 0);
    step(10'b0, 0, 1);
    for (int k = 0; k < 3; k++) step(10'(1 << (k + 4)), 0, 0);
    step(10'b0000000001, 0, 1);
    step(10'b0, 0, 0);
    step(10'b0, 1, 0);
    for (int k = 0; k < 65536; k++) step(10'(1 << $urandom_range(0, 9)), 1, 0);
    step(10'b0, 1, 0);
    step(10'b0, 1, 0);
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 3))
        0: m = '0;
        1: m = 10'($urandom);
        default: m = 10'(1 << $urandom_range(0, 9));
      endcase
      step(m, 1'($urandom_range(0, 2) == 0), $urandom_range(0, 199) == 0);
    end
    step(10'b0, 0, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
